// File: rtl/cia_tod_pkg.sv
// Shared encodings for the CIA TOD access sequencer: host op codes,
// the control-register alarm-select value and the bus sequencing states.
package cia_tod_pkg;

    localparam logic [1:0] OP_READ_TOD    = 2'd0;
    localparam logic [1:0] OP_WRITE_TOD   = 2'd1;
    localparam logic [1:0] OP_WRITE_ALARM = 2'd2;
    localparam logic [1:0] OP_READ_CRB    = 2'd3;

    // CRB bit 7 steers TOD byte writes to the alarm registers
    localparam logic [7:0] CRB_ALARM_SEL  = 8'h80;

    typedef enum logic [3:0] {
        IDLE,
        RD_HI,
        RD_MID,
        RD_LO,
        RD_CRB,
        WR_PRE,
        WR_HI,
        WR_MID,
        WR_LO,
        WR_POST
    } tod_state_t;

endpackage

// File: rtl/cia_tod_access.sv
// CIA TOD access sequencer: turns one 24-bit host request into the ordered
// byte accesses the TOD responder needs (high-first latched reads,
// stop/start write ordering, alarm-select bracketing around alarm writes).
module cia_tod_access
    import cia_tod_pkg::*;
#(
    parameter logic [7:0] TOD_PRE_CRB = 8'h00,
    parameter logic [7:0] CRB_RESTORE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [23:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [23:0] rdata,
    output logic        bus_wr,
    output logic        bus_tlo,
    output logic        bus_tme,
    output logic        bus_thi,
    output logic        bus_tcr,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din
);

    tod_state_t  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] wdata_q, wdata_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  mid_q, mid_d;
    logic [23:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wr_q, wr_d;
    logic        tlo_q, tlo_d;
    logic        tme_q, tme_d;
    logic        thi_q, thi_d;
    logic        tcr_q, tcr_d;
    logic [7:0]  dout_q, dout_d;

    // Next-state sequencing, then bus outputs decoded from the state being entered
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        mid_d   = mid_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    op_d    = op;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                    case (op)
                        OP_READ_TOD: state_d = RD_HI;
                        OP_READ_CRB: state_d = RD_CRB;
                        default:     state_d = WR_PRE;
                    endcase
                end
            end
            RD_HI: begin
                hi_d    = bus_din;
                state_d = RD_MID;
            end
            RD_MID: begin
                mid_d   = bus_din;
                state_d = RD_LO;
            end
            RD_LO: begin
                // all three bytes land together so no partial value is visible
                rdata_d = {hi_q, mid_q, bus_din};
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            RD_CRB: begin
                rdata_d = {16'd0, bus_din};
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            WR_PRE:  state_d = WR_HI;
            WR_HI:   state_d = WR_MID;
            WR_MID:  state_d = WR_LO;
            WR_LO: begin
                if (op_q == OP_WRITE_ALARM) begin
                    state_d = WR_POST;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_POST: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_d   = 1'b0;
        tlo_d  = 1'b0;
        tme_d  = 1'b0;
        thi_d  = 1'b0;
        tcr_d  = 1'b0;
        dout_d = 8'h00;
        case (state_d)
            RD_HI:  thi_d = 1'b1;
            RD_MID: tme_d = 1'b1;
            RD_LO:  tlo_d = 1'b1;
            RD_CRB: tcr_d = 1'b1;
            WR_PRE: begin
                tcr_d  = 1'b1;
                wr_d   = 1'b1;
                dout_d = (op_d == OP_WRITE_ALARM) ? CRB_ALARM_SEL : TOD_PRE_CRB;
            end
            WR_HI: begin
                thi_d  = 1'b1;
                wr_d   = 1'b1;
                dout_d = wdata_d[23:16];
            end
            WR_MID: begin
                tme_d  = 1'b1;
                wr_d   = 1'b1;
                dout_d = wdata_d[15:8];
            end
            WR_LO: begin
                tlo_d  = 1'b1;
                wr_d   = 1'b1;
                dout_d = wdata_d[7:0];
            end
            WR_POST: begin
                tcr_d  = 1'b1;
                wr_d   = 1'b1;
                dout_d = CRB_RESTORE;
            end
            default: ;
        endcase
    end

    // Control and bus registers: advance on ticks only, done self-clears every clk
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            tlo_q   <= 1'b0;
            tme_q   <= 1'b0;
            thi_q   <= 1'b0;
            tcr_q   <= 1'b0;
            dout_q  <= 8'h00;
            rdata_q <= 24'h000000;
        end else begin
            done_q <= clk7_en & done_d;
            if (clk7_en) begin
                state_q <= state_d;
                busy_q  <= busy_d;
                wr_q    <= wr_d;
                tlo_q   <= tlo_d;
                tme_q   <= tme_d;
                thi_q   <= thi_d;
                tcr_q   <= tcr_d;
                dout_q  <= dout_d;
                rdata_q <= rdata_d;
            end
        end
    end

    // Request latch and read shadow bytes; only meaningful while busy
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            op_q    <= op_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            mid_q   <= mid_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign bus_wr   = wr_q;
    assign bus_tlo  = tlo_q;
    assign bus_tme  = tme_q;
    assign bus_thi  = thi_q;
    assign bus_tcr  = tcr_q;
    assign bus_dout = dout_q;

endmodule

// File: tb/tb_cia_tod_access.sv
// Bench for cia_tod_access: a behavioural CIA TOD responder on the bus side,
// random and directed host requests, and a transaction-level model of the
// expected bus sequence, rdata and completion timing.
module tb_cia_tod_access;

    logic        clk;
    logic        reset;
    logic        clk7_en;
    logic        req;
    logic [1:0]  op;
    logic [23:0] wdata;
    logic        busy;
    logic        done;
    logic [23:0] rdata;
    logic        bus_wr;
    logic        bus_tlo;
    logic        bus_tme;
    logic        bus_thi;
    logic        bus_tcr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;

    cia_tod_access dut (
        .clk      (clk),
        .reset    (reset),
        .clk7_en  (clk7_en),
        .req      (req),
        .op       (op),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .bus_wr   (bus_wr),
        .bus_tlo  (bus_tlo),
        .bus_tme  (bus_tme),
        .bus_thi  (bus_thi),
        .bus_tcr  (bus_tcr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // clock and tick qualifier (one tick every third clk)
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int div;
    initial begin
        clk7_en = 1'b0;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            div = (div == 2) ? 0 : div + 1;
            clk7_en = (div == 0);
        end
    end

    // ---------------- behavioural TOD responder ----------------
    logic        resp_rst;
    logic        cnt_en;
    logic [23:0] r_tod, r_alarm, r_latch;
    logic [7:0]  r_crb;
    logic        r_latched, r_stopped, r_irq;
    logic        tod_wr;

    assign tod_wr = bus_wr && !r_crb[7] && (bus_thi || bus_tme || bus_tlo);

    always @(posedge clk) begin
        if (resp_rst) begin
            r_tod     <= 24'h123456;
            r_alarm   <= 24'hFFFFFF;
            r_latch   <= 24'h000000;
            r_crb     <= 8'h25;
            r_latched <= 1'b0;
            r_stopped <= 1'b1;
            r_irq     <= 1'b0;
        end else if (clk7_en) begin
            if (cnt_en && !r_stopped && !tod_wr) begin
                r_tod <= r_tod + 24'd1;
                if (r_tod + 24'd1 == r_alarm) r_irq <= 1'b1;
            end
            if (bus_wr) begin
                if (bus_tcr) begin
                    r_crb <= bus_dout;
                    if (!bus_dout[7]) r_stopped <= 1'b0;
                end
                if (bus_thi) begin
                    if (r_crb[7]) r_alarm[23:16] <= bus_dout;
                    else begin r_tod[23:16] <= bus_dout; r_stopped <= 1'b1; end
                end
                if (bus_tme) begin
                    if (r_crb[7]) r_alarm[15:8] <= bus_dout;
                    else r_tod[15:8] <= bus_dout;
                end
                if (bus_tlo) begin
                    if (r_crb[7]) r_alarm[7:0] <= bus_dout;
                    else begin r_tod[7:0] <= bus_dout; r_stopped <= 1'b0; end
                end
            end else begin
                if (bus_thi && !r_latched) begin
                    r_latch   <= r_tod;
                    r_latched <= 1'b1;
                end
                if (bus_tlo) r_latched <= 1'b0;
            end
        end
    end

    always_comb begin
        bus_din = 8'h00;
        if (!bus_wr) begin
            if (bus_thi)      bus_din = r_latched ? r_latch[23:16] : r_tod[23:16];
            else if (bus_tme) bus_din = r_latched ? r_latch[15:8]  : r_tod[15:8];
            else if (bus_tlo) bus_din = r_latched ? r_latch[7:0]   : r_tod[7:0];
            else if (bus_tcr) bus_din = r_crb;
        end
    end

    // ---------------- bus monitor ----------------
    // entry = {thi,tme,tlo,tcr, wr, dout}
    logic [12:0] obs_q[$];
    int          done_cnt = 0;
    int          excl_viol = 0;

    always @(negedge clk) begin
        if ($countones({bus_thi, bus_tme, bus_tlo, bus_tcr}) > 1) excl_viol++;
        if (done) done_cnt++;
        if (!reset && clk7_en && (bus_thi || bus_tme || bus_tlo || bus_tcr))
            obs_q.push_back({bus_thi, bus_tme, bus_tlo, bus_tcr, bus_wr, bus_dout});
    end

    // ---------------- reference model ----------------
    logic [23:0] model_tod = 24'h123456;
    logic [7:0]  model_crb = 8'h25;
    logic [23:0] rd_exp    = 24'h000000;

    localparam logic [3:0] S_HI = 4'b1000, S_MID = 4'b0100, S_LO = 4'b0010, S_CR = 4'b0001;

    // wait until posedge+2 where the following edge is (want=1) / is not (want=0) a tick
    task automatic wait_slot(input bit want);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (clk7_en == want) break;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [23:0] wd, input bit chk_rd);
        logic [12:0] eq[$];
        int  ticks;
        bit  got;
        case (o)
            2'd0: begin
                eq.push_back({S_HI, 1'b0, 8'h00});
                eq.push_back({S_MID, 1'b0, 8'h00});
                eq.push_back({S_LO, 1'b0, 8'h00});
            end
            2'd3: eq.push_back({S_CR, 1'b0, 8'h00});
            default: begin
                eq.push_back({S_CR, 1'b1, (o == 2'd2) ? 8'h80 : 8'h00});
                eq.push_back({S_HI, 1'b1, wd[23:16]});
                eq.push_back({S_MID, 1'b1, wd[15:8]});
                eq.push_back({S_LO, 1'b1, wd[7:0]});
                if (o == 2'd2) eq.push_back({S_CR, 1'b1, 8'h00});
            end
        endcase
        obs_q.delete();
        wait_slot(1'b1);
        op = o; wdata = wd; req = 1'b1;
        @(posedge clk);
        #2;
        req = 1'b0;
        check_eq("busy_after_accept", busy, 1);
        ticks = 0; got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            if (clk7_en) ticks++;
            #2;
            if (done) got = 1;
        end
        check_eq("done_seen", got, 1);
        check_eq("latency_ticks", ticks + 1, eq.size() + 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("strobes_idle", {bus_thi, bus_tme, bus_tlo, bus_tcr, bus_wr}, 0);
        check_eq("seq_len", obs_q.size(), eq.size());
        for (int i = 0; i < eq.size() && i < obs_q.size(); i++)
            check_eq($sformatf("seq[%0d] op%0d", i, o), obs_q[i], eq[i]);
        if (o == 2'd0) rd_exp = model_tod;
        if (o == 2'd3) rd_exp = {16'd0, model_crb};
        if (chk_rd) check_eq($sformatf("rdata op%0d", o), rdata, rd_exp);
        if (o == 2'd1) begin model_tod = wd; model_crb = 8'h00; end
        if (o == 2'd2) model_crb = 8'h00;
        @(posedge clk);
        #2;
        check_eq("done_one_clk", done, 0);
    endtask

    int d0;
    bit hit;

    initial begin
        reset = 1'b1; resp_rst = 1'b1; req = 1'b0; op = 2'd0; wdata = 24'd0; cnt_en = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_strobes", {bus_thi, bus_tme, bus_tlo, bus_tcr, bus_wr}, 0);
        check_eq("rst_dout", bus_dout, 0);
        check_eq("rst_rdata", rdata, 0);
        reset = 1'b0; resp_rst = 1'b0;

        // directed basics
        run_op(2'd3, 24'd0, 1);
        run_op(2'd0, 24'd0, 1);
        run_op(2'd1, 24'hABCDEF, 1);
        run_op(2'd0, 24'd0, 1);

        // random ops, counting off
        for (int k = 0; k < 16; k++)
            run_op(2'($urandom_range(0, 3)), 24'($urandom), 1);

        // req held while busy, and req on a non-tick cycle
        d0 = done_cnt;
        wait_slot(1'b1);
        op = 2'd0; req = 1'b1;
        @(posedge clk);
        for (int t = 0, c = 0; t < 2 && c < 20; c++) begin
            @(posedge clk);
            if (clk7_en) t++;
        end
        #2;
        req = 1'b0;
        for (int c = 0; c < 30 && busy; c++) begin @(posedge clk); #2; end
        wait_slot(1'b0);
        req = 1'b1;
        @(posedge clk);
        #2;
        req = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        check_eq("hold_done_count", done_cnt - d0, 1);
        check_eq("hold_busy", busy, 0);
        rd_exp = model_tod;
        check_eq("hold_rdata", rdata, rd_exp);

        // alarm write then count up to it
        run_op(2'd2, 24'h000010, 1);
        run_op(2'd1, 24'h000000, 1);
        check_eq("alarm_reg", r_alarm, 24'h000010);
        cnt_en = 1'b1;
        hit = 0;
        for (int c = 0; c < 300 && !hit; c++) begin @(posedge clk); #2; hit = r_irq; end
        cnt_en = 1'b0;
        check_eq("alarm_irq", hit, 1);
        check_eq("alarm_tod", r_tod, 24'h000010);
        run_op(2'd3, 24'd0, 1);

        // coherent read across a carry while counting every tick
        run_op(2'd1, 24'h00FFFE, 1);
        cnt_en = 1'b1;
        run_op(2'd0, 24'd0, 0);
        cnt_en = 1'b0;
        rd_exp = r_latch;
        check_eq("coherent_rdata", rdata, rd_exp);
        check_eq("coherent_window", (rdata >= 24'h00FFFE) && (rdata <= 24'h010008), 1);
        run_op(2'd1, 24'h345678, 1);

        // reset in WR_HI of WRITE_TOD
        wait_slot(1'b1);
        op = 2'd1; wdata = 24'hABCDEF; req = 1'b1;
        @(posedge clk);
        #2;
        req = 1'b0;
        d0 = done_cnt;
        for (int c = 0; c < 30 && !(bus_thi && bus_wr); c++) begin @(posedge clk); #2; end
        check_eq("rst_reach_wrhi", bus_thi & bus_wr, 1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check_eq("midrst_strobes", {bus_thi, bus_tme, bus_tlo, bus_tcr, bus_wr}, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_rdata", rdata, 0);
        check_eq("midrst_done", done, 0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check_eq("midrst_no_done", done_cnt - d0, 0);
        rd_exp = 24'h000000;
        model_crb = 8'h00;
        run_op(2'd3, 24'd0, 1);

        check_eq("strobe_exclusive", excl_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
